// File: rtl/simple_pkg.sv
// -----------------------------------------------------------------------------
// simple_pkg
// Shared types and constants for the SIMPLE pipeline register scoreboard.
//   ADR_W          register address width
//   sb_entry_t     one in-flight writer: {valid, adr, is_load}
//   SB_VALID..     register_invalid codes consumed by the ID-stage controller
//   sb_hit()       true when an entry is a valid writer of a given register
// -----------------------------------------------------------------------------
package simple_pkg;

    localparam int unsigned ADR_W = 3;

    typedef struct packed {
        logic             valid;
        logic [ADR_W-1:0] adr;
        logic             is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_ENTRY_EMPTY = '0;

    // register_invalid codes
    localparam logic [2:0] SB_VALID   = 3'd0;  // register file value is usable
    localparam logic [2:0] SB_STALL   = 3'd1;  // data not available yet
    localparam logic [2:0] SB_FWD_EX  = 3'd2;  // forward from EX result
    localparam logic [2:0] SB_FWD_MEM = 3'd3;  // forward from MEM result

    function automatic logic sb_hit(input sb_entry_t e, input logic [ADR_W-1:0] adr);
        return e.valid && (e.adr == adr);
    endfunction

endpackage

// File: rtl/sb_stage.sv
// -----------------------------------------------------------------------------
// sb_stage
// One scoreboard pipeline entry. Flush clears the entry and beats enable, so a
// flush lands even while the stage is held.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (entry becomes invalid)
//   i_en      load i_entry on the next edge
//   i_flush   invalidate the entry on the next edge (priority over i_en)
//   i_entry   upstream entry
//   o_entry   registered entry
// -----------------------------------------------------------------------------
module sb_stage
    import simple_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_en,
    input  logic      i_flush,
    input  sb_entry_t i_entry,
    output sb_entry_t o_entry
);

    sb_entry_t r_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= SB_ENTRY_EMPTY;
        end else if (i_flush) begin
            r_entry <= SB_ENTRY_EMPTY;
        end else if (i_en) begin
            r_entry <= i_entry;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/register_scoreboard.sv
// -----------------------------------------------------------------------------
// register_scoreboard
// Tracks the register writers sitting in EX, MEM and WB and reports, per
// architectural register, whether the ID stage may read it, must stall, or
// must forward from EX/MEM.
//
// Build option:
//   SB_FORWARD_EN  defined   : codes 0..3 (EX/MEM forwarding paths exist)
//                  undefined : any EX/MEM writer stalls; codes 2/3 never appear
//
// Parameters:
//   NUM_REGS   registers tracked (register 0 is ordinary, not hard-wired)
//   WB_BYPASS  1: write-first register file, WB writer reads as valid
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   regwrite_cur              ID instr writes a register and advances into EX
//   wr_adr_id                 destination of the ID instr
//   from_main_mem_id          ID instr is a load
//   en_*/flush_*              per-stage enable and flush (flush wins)
//   register_invalid[r]       hazard/forwarding code for register r
//   inflight_cnt              valid writers in EX+MEM+WB (0..3)
// -----------------------------------------------------------------------------
module register_scoreboard
    import simple_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 8,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      regwrite_cur,
    input  logic [ADR_W-1:0]          wr_adr_id,
    input  logic                      from_main_mem_id,
    input  logic                      en_idex,
    input  logic                      flush_idex,
    input  logic                      en_exmem,
    input  logic                      flush_exmem,
    input  logic                      en_memwb,
    input  logic                      flush_memwb,
    output logic [NUM_REGS-1:0][2:0]  register_invalid,
    output logic [1:0]                inflight_cnt
);

    sb_entry_t w_id;
    sb_entry_t w_ex;
    sb_entry_t w_mem;
    sb_entry_t w_wb;

    always_comb begin
        w_id         = SB_ENTRY_EMPTY;
        w_id.valid   = regwrite_cur;
        w_id.adr     = wr_adr_id;
        w_id.is_load = from_main_mem_id;
    end

    sb_stage u_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (en_idex),
        .i_flush (flush_idex),
        .i_entry (w_id),
        .o_entry (w_ex)
    );

    sb_stage u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (en_exmem),
        .i_flush (flush_exmem),
        .i_entry (w_ex),
        .o_entry (w_mem)
    );

    sb_stage u_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (en_memwb),
        .i_flush (flush_memwb),
        .i_entry (w_mem),
        .o_entry (w_wb)
    );

    // Load data is available once the load reaches MEM, so only the EX copy
    // of is_load matters (and only with forwarding).
    logic w_unused_is_load;
    assign w_unused_is_load = ^{w_ex.is_load, w_mem.is_load, w_wb.is_load};

    localparam logic [2:0] WbCode = WB_BYPASS ? SB_VALID : SB_STALL;

    // Youngest matching writer decides: EX, then MEM, then WB.
    always_comb begin
        register_invalid = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (sb_hit(w_ex, ADR_W'(r))) begin
`ifdef SB_FORWARD_EN
                register_invalid[r] = w_ex.is_load ? SB_STALL : SB_FWD_EX;
`else
                register_invalid[r] = SB_STALL;
`endif
            end else if (sb_hit(w_mem, ADR_W'(r))) begin
`ifdef SB_FORWARD_EN
                register_invalid[r] = SB_FWD_MEM;
`else
                register_invalid[r] = SB_STALL;
`endif
            end else if (sb_hit(w_wb, ADR_W'(r))) begin
                register_invalid[r] = WbCode;
            end else begin
                register_invalid[r] = SB_VALID;
            end
        end
    end

    assign inflight_cnt = 2'(w_ex.valid) + 2'(w_mem.valid) + 2'(w_wb.valid);

endmodule

// File: tb/tb_register_scoreboard.sv
module tb_register_scoreboard;

    logic            clk;
    logic            rst_n;
    logic            regwrite_cur;
    logic [2:0]      wr_adr_id;
    logic            from_main_mem_id;
    logic            en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb;
    logic [7:0][2:0] ri_b1, ri_b0;
    logic [1:0]      cnt_b1, cnt_b0;

    int n_vec = 0;
    int n_err = 0;

    register_scoreboard #(.NUM_REGS(8), .WB_BYPASS(1'b1)) dut_b1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .regwrite_cur     (regwrite_cur),
        .wr_adr_id        (wr_adr_id),
        .from_main_mem_id (from_main_mem_id),
        .en_idex          (en_idex),
        .flush_idex       (flush_idex),
        .en_exmem         (en_exmem),
        .flush_exmem      (flush_exmem),
        .en_memwb         (en_memwb),
        .flush_memwb      (flush_memwb),
        .register_invalid (ri_b1),
        .inflight_cnt     (cnt_b1)
    );

    register_scoreboard #(.NUM_REGS(8), .WB_BYPASS(1'b0)) dut_b0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .regwrite_cur     (regwrite_cur),
        .wr_adr_id        (wr_adr_id),
        .from_main_mem_id (from_main_mem_id),
        .en_idex          (en_idex),
        .flush_idex       (flush_idex),
        .en_exmem         (en_exmem),
        .flush_exmem      (flush_exmem),
        .en_memwb         (en_memwb),
        .flush_memwb      (flush_memwb),
        .register_invalid (ri_b0),
        .inflight_cnt     (cnt_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pipeline slots, index 0 = EX (youngest), 1 = MEM, 2 = WB.
    bit mv[3];
    int ma[3];
    bit ml[3];

    function automatic int exp_code(int r, bit byp);
        for (int s = 0; s < 3; s++) begin
            if (mv[s] && ma[s] == r) begin
                if (s == 2) return byp ? 0 : 1;
`ifdef SB_FORWARD_EN
                if (s == 0) return ml[0] ? 1 : 2;
                return 3;
`else
                return 1;
`endif
            end
        end
        return 0;
    endfunction

    function automatic int exp_cnt();
        return int'(mv[0]) + int'(mv[1]) + int'(mv[2]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            mv[s] = 1'b0;
            ma[s] = 0;
            ml[s] = 1'b0;
        end
    endtask

    // Oldest stage first so each stage sees its upstream's pre-edge value.
    task automatic model_edge();
        if (flush_memwb) mv[2] = 1'b0;
        else if (en_memwb) begin mv[2] = mv[1]; ma[2] = ma[1]; ml[2] = ml[1]; end
        if (flush_exmem) mv[1] = 1'b0;
        else if (en_exmem) begin mv[1] = mv[0]; ma[1] = ma[0]; ml[1] = ml[0]; end
        if (flush_idex) mv[0] = 1'b0;
        else if (en_idex) begin
            mv[0] = regwrite_cur;
            ma[0] = int'(wr_adr_id);
            ml[0] = from_main_mem_id;
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("%s byp1 reg%0d", tag, r), int'(ri_b1[r]), exp_code(r, 1'b1));
            chk($sformatf("%s byp0 reg%0d", tag, r), int'(ri_b0[r]), exp_code(r, 1'b0));
        end
        chk({tag, " byp1 inflight"}, int'(cnt_b1), exp_cnt());
        chk({tag, " byp0 inflight"}, int'(cnt_b0), exp_cnt());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit rw, input int adr, input bit ld,
                         input bit e_id, input bit f_id, input bit e_em, input bit f_em,
                         input bit e_mw, input bit f_mw);
        regwrite_cur     = rw;
        wr_adr_id        = 3'(adr);
        from_main_mem_id = ld;
        en_idex          = e_id;
        flush_idex       = f_id;
        en_exmem         = e_em;
        flush_exmem      = f_em;
        en_memwb         = e_mw;
        flush_memwb      = f_mw;
    endtask

    typedef struct {
        bit rw; int adr; bit ld;
        bit e_id; bit f_id; bit e_em; bit f_em; bit e_mw; bit f_mw;
        int chk_r; int exp_fwd; int exp_nofwd; int exp_cnt;
    } vec_t;

    function automatic vec_t mk(bit rw, int adr, bit ld, bit e_id, bit f_id, bit e_em,
                                bit f_em, bit e_mw, bit f_mw, int chk_r, int ef, int enf,
                                int cnt);
        vec_t v;
        v.rw = rw; v.adr = adr; v.ld = ld;
        v.e_id = e_id; v.f_id = f_id; v.e_em = e_em; v.f_em = f_em;
        v.e_mw = e_mw; v.f_mw = f_mw;
        v.chk_r = chk_r; v.exp_fwd = ef; v.exp_nofwd = enf; v.exp_cnt = cnt;
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        // Expected codes refer to the WB_BYPASS=1 instance.
        tbl[0]  = mk(1, 3, 0, 1, 0, 1, 0, 1, 0, 3, 2, 1, 1);  // ADD r3 in EX
        tbl[1]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 3, 3, 1, 1);  // r3 in MEM
        tbl[2]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 3, 0, 0, 1);  // r3 in WB
        tbl[3]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 3, 0, 0, 0);  // retired
        tbl[4]  = mk(1, 5, 1, 1, 0, 1, 0, 1, 0, 5, 1, 1, 1);  // LD r5 in EX
        tbl[5]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 5, 3, 1, 1);  // LD r5 in MEM
        tbl[6]  = mk(1, 2, 0, 1, 0, 1, 0, 1, 0, 2, 2, 1, 2);
        tbl[7]  = mk(1, 2, 0, 1, 0, 1, 0, 1, 0, 2, 2, 1, 2);  // r2 in EX and MEM
        tbl[8]  = mk(1, 6, 0, 1, 0, 1, 0, 1, 0, 6, 2, 1, 3);
        tbl[9]  = mk(1, 4, 0, 1, 0, 1, 0, 1, 0, 4, 2, 1, 3);  // ex=r4 mem=r6 wb=r2
        tbl[10] = mk(0, 0, 0, 1, 1, 1, 1, 1, 0, 4, 0, 0, 1);  // flush EX+MEM, r6 to WB
        tbl[11] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 6, 0, 0, 0);
        tbl[12] = mk(1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 2, 1, 1);
        tbl[13] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 3, 1, 1);  // r1 in MEM
        tbl[14] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 1);  // hold MEM/WB
        tbl[15] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 1);
        tbl[16] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1);  // released, r1 in WB
        tbl[17] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        tbl[18] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 2, 1, 1);  // r0 is ordinary
        tbl[19] = mk(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3, 1, 1);  // flush EX with en=0
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1);  // everything held
        tbl[21] = mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);  // flush WB with en=0
    end

    initial begin
        int expv;
        rst_n = 1'b0;
        drive(0, 0, 0, 1, 0, 1, 0, 1, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rw, tbl[i].adr, tbl[i].ld, tbl[i].e_id, tbl[i].f_id,
                  tbl[i].e_em, tbl[i].f_em, tbl[i].e_mw, tbl[i].f_mw);
            step();
`ifdef SB_FORWARD_EN
            expv = tbl[i].exp_fwd;
`else
            expv = tbl[i].exp_nofwd;
`endif
            chk($sformatf("tbl%0d reg%0d", i, tbl[i].chk_r), int'(ri_b1[tbl[i].chk_r]), expv);
            chk($sformatf("tbl%0d inflight", i), int'(cnt_b1), tbl[i].exp_cnt);
            check_all($sformatf("tbl%0d", i));
        end

        // ADD r7 through the WB_BYPASS=0 instance: stalls until it retires.
        drive(1, 7, 0, 1, 0, 1, 0, 1, 0);
        step();
`ifdef SB_FORWARD_EN
        chk("nobyp r7 c1", int'(ri_b0[7]), 2);
`else
        chk("nobyp r7 c1", int'(ri_b0[7]), 1);
`endif
        drive(0, 0, 0, 1, 0, 1, 0, 1, 0);
        step();
`ifdef SB_FORWARD_EN
        chk("nobyp r7 c2", int'(ri_b0[7]), 3);
`else
        chk("nobyp r7 c2", int'(ri_b0[7]), 1);
`endif
        step();
        chk("nobyp r7 c3", int'(ri_b0[7]), 1);
        step();
        chk("nobyp r7 c4", int'(ri_b0[7]), 0);
        check_all("r7seq");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            step();
            check_all($sformatf("rnd%0d", i));
        end

        // Fill all three stages, then reset asynchronously between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1, i + 2, 0, 1, 0, 1, 0, 1, 0);
            step();
        end
        chk("full inflight", int'(cnt_b1), 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async rst reg2", int'(ri_b1[2]), 0);
        chk("async rst inflight", int'(cnt_b1), 0);
        check_all("async_rst");
        #2;
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 1, 0, 1, 0);
        step();
        check_all("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
